// File: rtl/fa_response_checker.sv
// fa_response_checker
//
// Sequential self-test engine for a combinational full adder.
//
// One sweep applies the eight {x, y, c_in} vectors in ascending order
// 000..111. Each vector is held for SETTLE_CYCLES settle cycles plus one
// compare cycle. In the compare cycle the adder's sum and carry are checked
// against golden values computed here, and every mismatch increments err_cnt.
// When the sweep finishes, done pulses for one cycle and pass reports whether
// the sweep had zero mismatches.
//
// Optional feature (compile-time macro FA_CHK_FIRST_FAIL_EN):
//   When defined, the first failing vector of a sweep is captured in fail_vec
//   as {x, y, c_in, observed s, observed c}, and fail_valid is set.
//   When undefined, fail_vec and fail_valid are tied to 0. The ports remain
//   present in both builds.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (legal 1..255)
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request a sweep; only sampled in IDLE
//   dut_s       in   sum output of the adder under test
//   dut_c       in   carry output of the adder under test
//   x           out  stimulus to adder input x (vector bit 2)
//   y           out  stimulus to adder input y (vector bit 1)
//   c_in        out  stimulus to adder carry-in (vector bit 0)
//   busy        out  high while a sweep is in progress (SETTLE/COMPARE)
//   done        out  one-cycle pulse when a sweep completes
//   pass        out  last completed sweep had zero mismatches
//   err_cnt     out  mismatch count of the current/last sweep (0..8)
//   fail_valid  out  a failing vector has been captured
//   fail_vec    out  first failing {x, y, c_in, observed s, observed c}

module fa_response_checker #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_s,
  input  logic       dut_c,
  output logic       x,
  output logic       y,
  output logic       c_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic       fail_valid,
  output logic [4:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // The settle counter counts down from SETTLE_CYCLES-1 to 0, which gives
  // exactly SETTLE_CYCLES cycles in SETTLE for every vector.
  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] vec;
  logic [7:0] settle_cnt;

  // Decoded control strobes from the next-state logic
  logic accept;
  logic advance;
  logic stim_en;
  logic compare_en;

  logic gold_s;
  logic gold_c;
  logic mismatch;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    advance    = 1'b0;
    stim_en    = 1'b0;
    compare_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        busy    = 1'b1;
        stim_en = 1'b1;
        if (settle_cnt == 8'd0) begin
          state_nxt = COMPARE;
        end
      end

      COMPARE: begin
        busy       = 1'b1;
        stim_en    = 1'b1;
        compare_en = 1'b1;
        if (vec == 3'd7) begin
          state_nxt = DONE;
        end else begin
          advance   = 1'b1;
          state_nxt = SETTLE;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // vec holds 7 after a sweep. The stimulus is therefore gated so that the
  // adder sees 000 in IDLE and DONE.
  assign x    = stim_en & vec[2];
  assign y    = stim_en & vec[1];
  assign c_in = stim_en & vec[0];

  // Golden full-adder model
  assign gold_s   = vec[2] ^ vec[1] ^ vec[0];
  assign gold_c   = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  assign mismatch = compare_en & ((dut_s != gold_s) | (dut_c != gold_c));

  // Vector index and per-vector settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 3'd0;
      settle_cnt <= 8'd0;
    end else if (accept) begin
      vec        <= 3'd0;
      settle_cnt <= SETTLE_RELOAD;
    end else if (advance) begin
      vec        <= vec + 3'd1;
      settle_cnt <= SETTLE_RELOAD;
    end else if ((state == SETTLE) && (settle_cnt != 8'd0)) begin
      settle_cnt <= settle_cnt - 8'd1;
    end
  end

  // Result registers. pass is written in DONE, when err_cnt already includes
  // the final compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 4'd0;
      pass    <= 1'b0;
    end else if (accept) begin
      err_cnt <= 4'd0;
      pass    <= 1'b0;
    end else begin
      if (mismatch) begin
        err_cnt <= err_cnt + 4'd1;
      end
      if (state == DONE) begin
        pass <= (err_cnt == 4'd0);
      end
    end
  end

`ifdef FA_CHK_FIRST_FAIL_EN
  logic       fail_valid_q;
  logic [4:0] fail_vec_q;

  // First-failure capture. Once fail_valid_q is set, later mismatches in the
  // same sweep leave the captured vector untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 5'd0;
    end else if (accept) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 5'd0;
    end else if (mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_vec_q   <= {vec, dut_s, dut_c};
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = 5'd0;
`endif

endmodule

// File: doc/fa_response_checker.md
# fa_response_checker

Sequential self-test engine for the full adder. It sweeps all eight {x, y, c_in} input combinations into a full-adder instance, in ascending order 000 to 111. For each vector it waits a programmable settle time, then samples the adder's sum and carry and compares them against internally computed golden values. It counts mismatches and reports pass/fail through a start/busy/done handshake. It is the checking counterpart to the existing stimulus-only bench, and is used both on-chip and as a reusable bench component.

## Interface
- SETTLE_CYCLES, default 4: cycles each vector is held before sampling; legal range 1..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- dut_s  in  1  sum output of the adder under test
- dut_c  in  1  carry output of the adder under test
- x  out  1  stimulus bit to adder input x (vector bit 2)
- y  out  1  stimulus bit to adder input y (vector bit 1)
- c_in  out  1  stimulus bit to adder carry-in (vector bit 0)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the sweep completes
- pass  out  1  high when the last completed sweep had zero mismatches
- err_cnt  out  4  mismatch count, range 0..8
- fail_valid  out  1  a failing vector has been captured (see Configuration)
- fail_vec  out  5  first failing {x, y, c_in, observed s, observed c}

## Operation
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE, start=1:
  - vec ← 0; err_cnt ← 0; pass ← 0; fail_valid ← 0
  - settle counter ← SETTLE_CYCLES-1
  - go to SETTLE
- SETTLE:
  - {x, y, c_in} = vec
  - counter decrements each cycle
  - at counter=0, go to COMPARE
- COMPARE:
  - golden sum = x^y^c_in; golden carry = (x&y)|(x&c_in)|(y&c_in)
  - mismatch = (dut_s≠sum) or (dut_c≠carry); on mismatch, err_cnt += 1
  - vec=7: go to DONE
  - otherwise: vec += 1, counter reloaded, go to SETTLE
- DONE:
  - done=1 for one cycle
  - pass ← (final err_cnt == 0)
  - go to IDLE
- Stimulus in IDLE and DONE is 000.
- err_cnt, pass and fail_* hold their values until the next accepted start.
- vec is 3 bits and never wraps in-sweep; the sweep ends at 7.

## Timing
- Reset (async assert, sync release): state IDLE; x=y=c_in=0; busy=0, done=0, pass=0; err_cnt=0; fail_valid=0, fail_vec=0.
- Start accepted at edge T:
  - busy=1 and vector 000 driven from T+1
  - each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES settle cycles plus 1 compare cycle
  - dut_s/dut_c are sampled on the last cycle of each vector
- done is high in cycle T+8·(SETTLE_CYCLES+1)+1; busy falls in that same cycle. With default SETTLE_CYCLES=4, done is at T+41.
- start while busy or in DONE: ignored; no restart and no queueing.
- start held high continuously: a new sweep is accepted in the first IDLE cycle after DONE (back-to-back sweeps 1 cycle apart).
- Reset mid-sweep: immediate return to reset values; previous results are lost.
- The adder under test is combinational; SETTLE_CYCLES ≥ 1 guarantees at least one full cycle of settling.

## Configuration
- FA_CHK_FIRST_FAIL_EN defined:
  - on the first mismatch of a sweep, fail_vec ← {x, y, c_in, dut_s, dut_c} and fail_valid ← 1
  - later mismatches do not overwrite the capture
- Undefined:
  - fail_vec and fail_valid are tied to 0
  - ports remain present
  - err_cnt and pass are unaffected

## Test plan
- Correct adder, SETTLE_CYCLES=4, start pulse at T → done at T+41; pass=1; err_cnt=0; stimulus sequence 000..111 each held 5 cycles.
- Adder with sum stuck at 0 → err_cnt=4 (vectors 001, 010, 100, 111); pass=0. With FA_CHK_FIRST_FAIL_EN: fail_vec=5'b00100, fail_valid=1.
- Adder with carry inverted → err_cnt=8; pass=0; with the macro: fail_vec=5'b00001.
- start pulsed at sweep cycles 3 and 20 → ignored; done occurs exactly once, at T+41.
- rst_n asserted at T+17 → all outputs 0 within the same cycle; new start after release → full clean sweep with pass=1.
- SETTLE_CYCLES=1, start held high → done every 18 cycles (17-cycle sweep plus 1 IDLE cycle); results reset at each new acceptance.
